// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix multiplier host and its benches:
// element width, host FSM encoding, and MSB-first slot packing helpers.
package matrix_pkg;

  localparam int ELEMENT_LENGTH = 32;

  // Host controller states.
  typedef enum logic [2:0] {
    ST_FILL_A = 3'd0,
    ST_FILL_B = 3'd1,
    ST_LOAD   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_ACK    = 3'd4,
    ST_SEND   = 3'd5
  } host_state_e;

  // Bits needed to count 0..value-1, never less than one bit.
  function automatic int clog2_min1(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    if (w < 1) w = 1;
    return w;
  endfunction

  // LSB position of slot 'slot' in a bus of 'num_slots' elements, where
  // slot 0 sits in the most significant element position.
  function automatic int slot_lsb(input int num_slots, input int slot);
    return (num_slots - 1 - slot) * ELEMENT_LENGTH;
  endfunction

endpackage

// File: rtl/matrix_result_serializer.sv
// Holds the captured multiplier result and streams it out one element per
// valid/ready handshake, in row-major slot order.
module matrix_result_serializer
  import matrix_pkg::*;
#(
  parameter int NUM_ELEMS = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                capture_i,
  input  logic                                send_i,
  input  logic [NUM_ELEMS*ELEMENT_LENGTH-1:0] result_i,
  input  logic                                out_taken_i,
  output logic [ELEMENT_LENGTH-1:0]           out_data_o,
  output logic                                out_valid_o,
  output logic                                last_take_o
);

  localparam int W  = NUM_ELEMS * ELEMENT_LENGTH;
  localparam int OW = clog2_min1(NUM_ELEMS);

  logic [W-1:0]  res_q, res_d;
  logic [OW-1:0] o_cnt_q, o_cnt_d;
  logic          take;

  // A take only counts while the element is actually offered.
  assign out_valid_o = send_i;
  assign take        = send_i & out_taken_i;
  assign last_take_o = take && (o_cnt_q == OW'(NUM_ELEMS - 1));

  // Next-state for the result register and output element counter.
  always_comb begin
    res_d   = res_q;
    o_cnt_d = o_cnt_q;
    if (capture_i) begin
      res_d   = result_i;
      o_cnt_d = '0;
    end
    if (take) begin
      o_cnt_d = last_take_o ? '0 : o_cnt_q + OW'(1);
    end
  end

  // Result register and counter, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_q   <= '0;
      o_cnt_q <= '0;
    end else begin
      res_q   <= res_d;
      o_cnt_q <= o_cnt_d;
    end
  end

  // Select the element addressed by the output counter.
  always_comb begin
    out_data_o = '0;
    for (int i = 0; i < NUM_ELEMS; i++) begin
      if (o_cnt_q == OW'(i)) out_data_o = res_q[slot_lsb(NUM_ELEMS, i) +: ELEMENT_LENGTH];
    end
  end

endmodule

// File: rtl/matrix_stream_host.sv
// Host-side controller for the floating-point matrix multiplier: gathers A
// (row-major) and B (row-major, remapped to column-major) from a word stream,
// starts the multiplier, captures and acknowledges its result, then streams
// the result back out row-major.
//
// Handshakes: an element moves on a rising edge exactly when its valid and
// ready are both high in the preceding cycle; valid from a sender never
// depends on ready, and a receiver ignores valid while its ready is low.
module matrix_stream_host
  import matrix_pkg::*;
#(
  parameter int NUM_FIRST_ROW  = 2,
  parameter int NUM_FIRST_COL  = 2,
  parameter int NUM_SECOND_COL = 2
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic [ELEMENT_LENGTH-1:0]                              in_data,
  input  logic                                                   in_valid,
  output logic                                                   in_ready,
  output logic [ELEMENT_LENGTH-1:0]                              out_data,
  output logic                                                   out_valid,
  input  logic                                                   out_taken,
  output logic [ELEMENT_LENGTH*NUM_FIRST_ROW*NUM_FIRST_COL-1:0]  mm_In1,
  output logic [ELEMENT_LENGTH*NUM_FIRST_COL*NUM_SECOND_COL-1:0] mm_In2,
  output logic                                                   mm_load,
  input  logic [ELEMENT_LENGTH*NUM_FIRST_ROW*NUM_SECOND_COL-1:0] mm_Out,
  input  logic                                                   mm_out_ready,
  output logic                                                   mm_out_ack,
  output logic [2:0]                                             dbg_state_o
);

  localparam int R  = NUM_FIRST_ROW;
  localparam int C  = NUM_FIRST_COL;
  localparam int K  = NUM_SECOND_COL;
  localparam int AC = R * C;
  localparam int BC = C * K;
  localparam int OC = R * K;
  localparam int AW = clog2_min1(AC);
  localparam int RW = clog2_min1(C);
  localparam int CW = clog2_min1(K);

  host_state_e state_q, state_d;

  logic                       armed_q;
  logic [AW-1:0]              a_cnt_q, a_cnt_d;
  logic [RW-1:0]              br_q, br_d;
  logic [CW-1:0]              bc_q, bc_d;
  logic [AC*ELEMENT_LENGTH-1:0] in1_q, in1_d;
  logic [BC*ELEMENT_LENGTH-1:0] in2_q, in2_d;

  logic accept;
  logic a_last, br_last, bc_last, b_last;
  logic capture, send, last_take;

  // Ready is held low for the first cycle out of reset, then follows the fill states.
  assign in_ready = armed_q && ((state_q == ST_FILL_A) || (state_q == ST_FILL_B));
  assign accept   = in_valid & in_ready;

  assign a_last  = (a_cnt_q == AW'(AC - 1));
  assign br_last = (br_q == RW'(C - 1));
  assign bc_last = (bc_q == CW'(K - 1));
  assign b_last  = br_last & bc_last;

  assign capture = (state_q == ST_WAIT) && mm_out_ready;
  assign send    = (state_q == ST_SEND);

  assign mm_In1      = in1_q;
  assign mm_In2      = in2_q;
  assign dbg_state_o = state_q;

  // State register plus the one-shot arming flag for in_ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_FILL_A;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
    end
  end

  // Next-state and the multiplier strobes.
  always_comb begin
    state_d    = state_q;
    mm_load    = 1'b0;
    mm_out_ack = 1'b0;
    case (state_q)
      ST_FILL_A: if (accept && a_last) state_d = ST_FILL_B;
      ST_FILL_B: if (accept && b_last) state_d = ST_LOAD;
      ST_LOAD: begin
        mm_load = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT:   if (mm_out_ready) state_d = ST_ACK;
      ST_ACK: begin
        mm_out_ack = 1'b1;
        state_d    = ST_SEND;
      end
      ST_SEND:   if (last_take) state_d = ST_FILL_A;
      default:   state_d = ST_FILL_A;
    endcase
  end

  // Operand write path: A lands row-major; B arrives row-major and is
  // stored column-major using separate row/column counters.
  always_comb begin
    in1_d   = in1_q;
    in2_d   = in2_q;
    a_cnt_d = a_cnt_q;
    br_d    = br_q;
    bc_d    = bc_q;
    if (accept && (state_q == ST_FILL_A)) begin
      for (int i = 0; i < AC; i++) begin
        if (a_cnt_q == AW'(i)) in1_d[slot_lsb(AC, i) +: ELEMENT_LENGTH] = in_data;
      end
      a_cnt_d = a_last ? '0 : a_cnt_q + AW'(1);
    end
    if (accept && (state_q == ST_FILL_B)) begin
      for (int r = 0; r < C; r++) begin
        for (int c = 0; c < K; c++) begin
          if ((br_q == RW'(r)) && (bc_q == CW'(c)))
            in2_d[slot_lsb(BC, c * C + r) +: ELEMENT_LENGTH] = in_data;
        end
      end
      if (bc_last) begin
        bc_d = '0;
        br_d = br_last ? '0 : br_q + RW'(1);
      end else begin
        bc_d = bc_q + CW'(1);
      end
    end
  end

  // Operand registers and fill counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in1_q   <= '0;
      in2_q   <= '0;
      a_cnt_q <= '0;
      br_q    <= '0;
      bc_q    <= '0;
    end else begin
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      a_cnt_q <= a_cnt_d;
      br_q    <= br_d;
      bc_q    <= bc_d;
    end
  end

  matrix_result_serializer #(
    .NUM_ELEMS (OC)
  ) u_serializer (
    .clk         (clk),
    .rst         (rst),
    .capture_i   (capture),
    .send_i      (send),
    .result_i    (mm_Out),
    .out_taken_i (out_taken),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .last_take_o (last_take)
  );

endmodule

// File: tb/tb_matrix_stream_host.sv
// Bench for matrix_stream_host: two instances (2x2x2 and 3x2x4), one active
// at a time. The bench plays the multiplier, using small integer-valued
// floats so products are exact and can be computed with integer arithmetic.
module tb_matrix_stream_host;
  import matrix_pkg::*;

  localparam int MAXWO = 384;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             sel;
  logic [31:0]      in_data;
  logic             in_valid, out_taken, mm_out_ready;
  logic [MAXWO-1:0] mm_out_bus;

  logic         in_ready_a, out_valid_a, mm_load_a, mm_out_ack_a;
  logic [31:0]  out_data_a;
  logic [127:0] in1_a, in2_a;
  logic [2:0]   dbg_a;

  logic         in_ready_b, out_valid_b, mm_load_b, mm_out_ack_b;
  logic [31:0]  out_data_b;
  logic [191:0] in1_b;
  logic [255:0] in2_b;
  logic [2:0]   dbg_b;

  logic             in_ready_m, out_valid_m, mm_load_m, mm_out_ack_m;
  logic [31:0]      out_data_m;
  logic [2:0]       dbg_m;
  logic [MAXWO-1:0] in1_m, in2_m;

  matrix_stream_host #(.NUM_FIRST_ROW(2), .NUM_FIRST_COL(2), .NUM_SECOND_COL(2)) u_dut_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid & ~sel), .in_ready(in_ready_a),
    .out_data(out_data_a), .out_valid(out_valid_a), .out_taken(out_taken & ~sel),
    .mm_In1(in1_a), .mm_In2(in2_a), .mm_load(mm_load_a), .mm_Out(mm_out_bus[127:0]),
    .mm_out_ready(mm_out_ready & ~sel), .mm_out_ack(mm_out_ack_a), .dbg_state_o(dbg_a)
  );

  matrix_stream_host #(.NUM_FIRST_ROW(3), .NUM_FIRST_COL(2), .NUM_SECOND_COL(4)) u_dut_b (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid & sel), .in_ready(in_ready_b),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_taken(out_taken & sel),
    .mm_In1(in1_b), .mm_In2(in2_b), .mm_load(mm_load_b), .mm_Out(mm_out_bus),
    .mm_out_ready(mm_out_ready & sel), .mm_out_ack(mm_out_ack_b), .dbg_state_o(dbg_b)
  );

  assign in_ready_m   = sel ? in_ready_b   : in_ready_a;
  assign out_valid_m  = sel ? out_valid_b  : out_valid_a;
  assign mm_load_m    = sel ? mm_load_b    : mm_load_a;
  assign mm_out_ack_m = sel ? mm_out_ack_b : mm_out_ack_a;
  assign out_data_m   = sel ? out_data_b   : out_data_a;
  assign dbg_m        = sel ? dbg_b        : dbg_a;

  always_comb begin
    in1_m = '0;
    in2_m = '0;
    if (sel) begin
      in1_m[191:0] = in1_b;
      in2_m[255:0] = in2_b;
    end else begin
      in1_m[127:0] = in1_a;
      in2_m[127:0] = in2_a;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int R, C, K;
  int a_m[12];
  int b_m[12];
  logic [31:0] exp_q[$];

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic checkw(input string tag, input logic [MAXWO-1:0] obs, input logic [MAXWO-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Small non-negative integer to IEEE-754 single.
  function automatic logic [31:0] int_to_f32(input int v);
    int e;
    logic [31:0] m;
    if (v == 0) return 32'h0;
    e = 0;
    while ((v >> (e + 1)) != 0) e++;
    m = 32'(v) << (23 - e);
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  // IEEE-754 single holding a small integer back to int (-1 if not one).
  function automatic int f32_to_int(input logic [31:0] f);
    int e;
    logic [31:0] t;
    if (f[30:0] == 31'h0) return 0;
    e = int'(f[30:23]) - 127;
    if (e < 0 || e > 23) return -1;
    t = {8'h0, 1'b1, f[22:0]};
    return int'(t >> (23 - e));
  endfunction

  function automatic logic [31:0] slot_get(input logic [MAXWO-1:0] v, input int n_total, input int n);
    return v[32*(n_total-n)-1 -: 32];
  endfunction

  function automatic logic [MAXWO-1:0] put_slot(input logic [MAXWO-1:0] v, input int n_total,
                                                input int n, input logic [31:0] x);
    v[32*(n_total-n)-1 -: 32] = x;
    return v;
  endfunction

  // A row-major packed, element 0 at the top.
  function automatic logic [MAXWO-1:0] exp_in1();
    logic [MAXWO-1:0] v;
    v = '0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        v = put_slot(v, R*C, r*C + c, int_to_f32(a_m[r*C + c]));
    return v;
  endfunction

  // B (C x K) packed column-major: B(r,c) in slot c*C+r.
  function automatic logic [MAXWO-1:0] exp_in2();
    logic [MAXWO-1:0] v;
    v = '0;
    for (int r = 0; r < C; r++)
      for (int c = 0; c < K; c++)
        v = put_slot(v, C*K, c*C + r, int_to_f32(b_m[r*K + c]));
    return v;
  endfunction

  task automatic gen_mats();
    for (int i = 0; i < R*C; i++) a_m[i] = int'($urandom_range(0, 15));
    for (int i = 0; i < C*K; i++) b_m[i] = int'($urandom_range(0, 15));
  endtask

  // Reference product A*B, row-major, queued as floats.
  task automatic build_exp();
    int acc;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < K; j++) begin
        acc = 0;
        for (int t = 0; t < C; t++) acc += a_m[i*C + t] * b_m[t*K + j];
        exp_q.push_back(int_to_f32(acc));
      end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    out_taken = 1'b0;
    mm_out_ready = 1'b0;
    in_data = '0;
    #1;
    check1("rst_in_ready", in_ready_m, 1'b0);
    check1("rst_out_valid", out_valid_m, 1'b0);
    check1("rst_mm_load", mm_load_m, 1'b0);
    check1("rst_mm_out_ack", mm_out_ack_m, 1'b0);
    checkw("rst_mm_In1", in1_m, '0);
    checkw("rst_mm_In2", in2_m, '0);
    check32("rst_out_data", out_data_m, 32'h0);
    check32("rst_state", 32'(dbg_m), 32'(ST_FILL_A));
    @(negedge clk);
    rst = 1'b1;
    check1("rst_release_ready_low", in_ready_m, 1'b0);
    @(negedge clk);
    check1("rst_first_edge_ready", in_ready_m, 1'b1);
  endtask

  // Streams A then B; returns in the first WAIT cycle.
  task automatic feed(input bit rand_valid, input bit ready_fill, input bit hold_valid);
    logic [31:0] stream[$];
    stream = {};
    for (int i = 0; i < R*C; i++) stream.push_back(int_to_f32(a_m[i]));
    for (int i = 0; i < C*K; i++) stream.push_back(int_to_f32(b_m[i]));
    if (ready_fill) mm_out_ready = 1'b1;
    for (int i = 0; i < stream.size(); i++) begin
      while (rand_valid && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_data = $urandom;
        check1("bubble_ready", in_ready_m, 1'b1);
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data = stream[i];
      check1("fill_ready", in_ready_m, 1'b1);
      check1("fill_no_load", mm_load_m, 1'b0);
      if (ready_fill) check1("fill_no_ack", mm_out_ack_m, 1'b0);
      @(negedge clk);
    end
    in_valid = hold_valid;
    if (ready_fill) mm_out_ready = 1'b0;
    check1("load_pulse", mm_load_m, 1'b1);
    check1("load_not_ready", in_ready_m, 1'b0);
    check1("load_no_ack", mm_out_ack_m, 1'b0);
    checkw("mm_In1_packed", in1_m, exp_in1());
    checkw("mm_In2_packed", in2_m, exp_in2());
    @(negedge clk);
    check1("load_once", mm_load_m, 1'b0);
    check1("wait_not_ready", in_ready_m, 1'b0);
  endtask

  // Acts as the multiplier on the DUT's packed buses, then handshakes.
  task automatic multiply(input int lat);
    logic [MAXWO-1:0] v;
    int acc;
    v = '0;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < K; j++) begin
        acc = 0;
        for (int t = 0; t < C; t++)
          acc += f32_to_int(slot_get(in1_m, R*C, i*C + t)) * f32_to_int(slot_get(in2_m, C*K, j*C + t));
        v = put_slot(v, R*K, i*K + j, int_to_f32(acc));
      end
    mm_out_bus = v;
    for (int l = 0; l < lat; l++) begin
      check1("wait_no_ack", mm_out_ack_m, 1'b0);
      check1("wait_no_valid", out_valid_m, 1'b0);
      @(negedge clk);
    end
    mm_out_ready = 1'b1;
    @(negedge clk);
    check1("ack_pulse", mm_out_ack_m, 1'b1);
    check1("ack_no_valid", out_valid_m, 1'b0);
    @(negedge clk);
    mm_out_ready = 1'b0;
    check1("ack_once", mm_out_ack_m, 1'b0);
    check1("send_valid", out_valid_m, 1'b1);
  endtask

  // Takes the result; stop_after >= 0 abandons after that many takes.
  task automatic drain(input int hold, input bit rand_take, input int stop_after);
    for (int k = 0; k < R*K; k++) begin
      logic [31:0] e;
      int h;
      if (k == stop_after) begin
        out_taken = 1'b0;
        return;
      end
      e = exp_q.pop_front();
      h = (k == 0) ? hold : (rand_take ? int'($urandom_range(0, 2)) : 0);
      out_taken = 1'b0;
      for (int c = 0; c < h; c++) begin
        check32("held_out_data", out_data_m, e);
        check1("held_out_valid", out_valid_m, 1'b1);
        @(negedge clk);
      end
      out_taken = 1'b1;
      check32("out_data", out_data_m, e);
      check1("out_valid", out_valid_m, 1'b1);
      check1("send_not_ready", in_ready_m, 1'b0);
      @(negedge clk);
    end
    out_taken = 1'b0;
    check1("done_valid_low", out_valid_m, 1'b0);
    check1("done_ready_high", in_ready_m, 1'b1);
  endtask

  initial begin
    sel = 1'b0;
    R = 2; C = 2; K = 2;
    in_valid = 1'b0; out_taken = 1'b0; mm_out_ready = 1'b0;
    in_data = '0; mm_out_bus = '0;
    #2;
    do_reset();

    // Fixed operands with literal expected result.
    a_m[0] = 1; a_m[1] = 2; a_m[2] = 3; a_m[3] = 4;
    b_m[0] = 5; b_m[1] = 6; b_m[2] = 7; b_m[3] = 8;
    exp_q = {32'h41980000, 32'h41B00000, 32'h422C0000, 32'h42480000};
    feed(1'b0, 1'b0, 1'b0);
    multiply(2);
    drain(0, 1'b0, -1);

    // Same data, ragged input valid, output held off for ten cycles.
    exp_q = {32'h41980000, 32'h41B00000, 32'h422C0000, 32'h42480000};
    feed(1'b1, 1'b0, 1'b0);
    multiply(0);
    drain(10, 1'b1, -1);

    // Multiplier ready asserted early must be ignored during fill.
    gen_mats();
    build_exp();
    feed(1'b0, 1'b1, 1'b0);
    multiply(1);
    drain(0, 1'b0, -1);

    // Reset while waiting on the multiplier.
    gen_mats();
    feed(1'b1, 1'b0, 1'b0);
    do_reset();

    // Reset part way through sending the result.
    gen_mats();
    build_exp();
    feed(1'b0, 1'b0, 1'b0);
    multiply(1);
    drain(0, 1'b1, 2);
    exp_q.delete();
    do_reset();

    // Clean transaction afterwards.
    gen_mats();
    build_exp();
    feed(1'b1, 1'b0, 1'b0);
    multiply(3);
    drain(0, 1'b1, -1);

    // Back-to-back transactions with input valid held high.
    gen_mats();
    build_exp();
    feed(1'b0, 1'b0, 1'b1);
    multiply(0);
    gen_mats();
    build_exp();
    in_valid = 1'b1;
    in_data = int_to_f32(a_m[0]);
    drain(0, 1'b0, -1);
    feed(1'b0, 1'b0, 1'b0);
    multiply(0);
    drain(0, 1'b0, -1);

    // Rectangular instance: A 3x2 random, B 2x4 = 0..7.
    sel = 1'b1;
    R = 3; C = 2; K = 4;
    do_reset();
    gen_mats();
    for (int i = 0; i < 8; i++) b_m[i] = i;
    build_exp();
    feed(1'b1, 1'b0, 1'b0);
    multiply(2);
    drain(3, 1'b1, -1);

    gen_mats();
    build_exp();
    feed(1'b0, 1'b1, 1'b0);
    multiply(0);
    drain(0, 1'b1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/matrix_stream_host.md
# matrix_stream_host

Host-side controller for the floating-point matrix multiplier. It assembles two IEEE-754 single-precision operand matrices from a 32-bit element stream and packs them into the multiplier's flat operand buses. It starts the product with `load`, captures the flat result on `out_ready`, and acknowledges it with `out_ack`. It then streams the result out one element per handshake. It sits between a byte/word-oriented front end (UART/DMA bridge) and the multiplier.

## Interface
- NUM_FIRST_ROW, 2, rows of A (R)
- NUM_FIRST_COL, 2, cols of A = rows of B (C)
- NUM_SECOND_COL, 2, cols of B (K)
- clk  in  1  clock (rising edge)
- rst  in  1  asynchronous, active-low reset
- in_data  in  32  operand element
- in_valid  in  1  in_data valid
- in_ready  out  1  host accepts element this cycle
- out_data  out  32  result element
- out_valid  out  1  out_data valid
- out_taken  in  1  consumer takes out_data this cycle
- mm_In1  out  32·R·C  A packed for multiplier
- mm_In2  out  32·C·K  B packed for multiplier
- mm_load  out  1  start pulse to multiplier
- mm_Out  in  32·R·K  multiplier result
- mm_out_ready  in  1  multiplier result valid (level)
- mm_out_ack  out  1  result consumed pulse

## Operation
- Packing uses element 0 at the MSB slice, i.e. slice n occupies bits [W-1-32n : W-32-32n].
- mm_In1 is A row-major: slot r·C+c.
- mm_In2 is B column-major: slot c·C+r for B(r,c).
- mm_Out is row-major: slot i·K+j.
- Input order on the stream: R·C elements of A row-major, then C·K elements of B row-major. The host performs the row-to-column remap for B.
- Output order on the stream: R·K result elements row-major.
- FSM states and transitions:
  - FILL_A: in_ready=1. Each accept writes slot a_cnt of mm_In1. After R·C accepts → FILL_B.
  - FILL_B: in_ready=1. Each accept writes B(r,c) to slot c·C+r; r and c are tracked with separate wrapping counters, with no divider. After C·K accepts → LOAD.
  - LOAD: mm_load=1 for exactly one cycle → WAIT.
  - WAIT: when mm_out_ready=1, capture mm_Out into the result register → ACK.
  - ACK: mm_out_ack=1 for exactly one cycle → SEND.
  - SEND: out_valid=1, out_data=result slot o_cnt. On out_taken, o_cnt increments. After the R·K-th take → FILL_A, with all counters cleared.
- mm_In1 and mm_In2 are registers. They stay stable from LOAD until the next FILL_A write.
- mm_out_ready is ignored in every state except WAIT.
- in_valid is ignored when in_ready=0. out_taken is ignored when out_valid=0.
- No arithmetic on element values. Counters are sized with clog2 of their limit (minimum 1 bit) and wrap to 0 at the limit.

## Timing
- Reset (rst low, async) values:
  - state FILL_A; all counters 0.
  - in_ready=0, out_valid=0, mm_load=0, mm_out_ack=0.
  - mm_In1, mm_In2, the result register and out_data are all 0.
- in_ready rises on the first clk edge after rst deasserts.
- An element is accepted on the edge where in_valid & in_ready. Full throughput is one element per cycle; no bubble between A and B.
- Last B accept at edge N: in_ready=0 and mm_load=1 during cycle N+1, WAIT from N+2.
- mm_out_ready sampled high at edge M: result captured at M, mm_out_ack=1 during cycle M+1, out_valid=1 from M+2.
- In SEND, out_data changes only on the edge after a take. Back-to-back takes give one element per cycle.
- Last take at edge P: out_valid=0 and in_ready=1 from P+1. In_valid during SEND is held off, never dropped.
- rst asserted mid-operation (any state, including a mm_load or mm_out_ack cycle): the host returns to reset values immediately and no partial result is emitted.

## Structure
- Shared package `matrix_pkg`:
  - ELEMENT_LENGTH=32.
  - State encodings.
  - clog2 helper.
  - Slot-offset function for MSB-first packing, shared with the multiplier bench.
- One natural sub-module: `matrix_result_serializer`, covering the result register, o_cnt and the out_valid/out_taken handshake. The FSM drives capture and start.

## Test plan
- R=C=K=2. Stream A=[1,2;3,4] (0x3F800000, 0x40000000, 0x40400000, 0x40800000) and B=[5,6;7,8] (0x40A00000, 0x40C00000, 0x40E00000, 0x41000000) → mm_In1={3F800000,40000000,40400000,40800000} and mm_In2={40A00000,40E00000,40C00000,41000000}. Then the output stream is 0x41980000, 0x41B00000, 0x422C0000, 0x42480000 (19, 22, 43, 50).
- Same data with in_valid toggled randomly and out_taken held low for 10 cycles → identical results, out_data stable while held, and exactly four takes.
- mm_out_ready forced high during FILL_A/FILL_B → no capture and no mm_out_ack. mm_load pulses exactly once, one cycle after the 8th accept.
- Assert rst during WAIT and again during SEND after 2 takes → all outputs at reset values. The next full transaction produces the correct result with no stale elements.
- R=3, C=2, K=4: B row-major 0..7 (as floats) → mm_In2 slot order B(0,0), B(1,0), B(0,1), B(1,1), …. Output is 12 elements row-major matching the reference product.
- Two transactions back-to-back with in_valid held high → in_ready=0 throughout SEND. The first element of the second A is accepted in the cycle after the last take.
